// File: rtl/uart_pkg.sv
// Shared definitions for the UART block sender: byte width, FSM state
// encoding and the byte-order reversal helper.
package uart_pkg;

  localparam int BYTE_W    = 8;
  // Widest block the reversal helper handles; callers zero-extend into it.
  localparam int MAX_BYTES = 16;
  localparam int MAX_W     = BYTE_W * MAX_BYTES;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_ARM,
    S_HOLD,
    S_RELEASE,
    S_FIN
  } uart_blk_state_t;

  // Reverse the byte order of the low nbytes bytes; upper bytes become zero.
  // With a constant nbytes this folds to pure wiring.
  function automatic logic [MAX_W-1:0] reverse_bytes(input logic [MAX_W-1:0] data,
                                                      input int nbytes);
    logic [MAX_W-1:0] res;
    res = '0;
    for (int i = 0; i < MAX_BYTES; i++) begin
      if (i < nbytes) begin
        res[BYTE_W*i +: BYTE_W] = data[BYTE_W*(nbytes-1-i) +: BYTE_W];
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/uart_block_sender.sv
// Serializes one NBYTES block into bytes for an edge-triggered UART
// transmitter (start / tx_rdy handshake). Upstream is valid/ready.
// Optional macro UART_BLOCK_CKSUM_EN appends an XOR checksum byte.
module uart_block_sender
  import uart_pkg::*;
#(
  parameter int NBYTES    = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [8*NBYTES-1:0]  blk_data,
  input  logic                 blk_valid,
  output logic                 blk_ready,
  output logic [7:0]           byte_out,
  output logic                 byte_start,
  input  logic                 uart_tx_rdy,
  output logic                 busy,
  output logic                 done
);

  localparam int W  = BYTE_W * NBYTES;
  localparam int CW = $clog2(NBYTES + 1);
  localparam logic [CW-1:0] C_ONE = CW'(1);
`ifdef UART_BLOCK_CKSUM_EN
  // Counter value while the checksum byte is in flight.
  localparam logic [CW-1:0] C_CKSUM = CW'(NBYTES);
`else
  localparam logic [CW-1:0] C_LAST  = CW'(NBYTES - 1);
`endif

  uart_blk_state_t   r_state, w_state_nxt;
  // Shift register holds bytes in send order, next byte at the bottom.
  logic [MAX_W-1:0]  r_shift, w_shift_nxt;
  logic [CW-1:0]     r_cnt, w_cnt_nxt;
  logic [7:0]        r_byte, w_byte_nxt;
  logic              r_start, w_start_nxt;
  logic              r_busy, w_busy_nxt;
  logic [MAX_W-1:0]  w_ext;
  logic [MAX_W-1:0]  w_load;
  logic [7:0]        w_cur;
`ifdef UART_BLOCK_CKSUM_EN
  logic [7:0]        r_cksum, w_cksum_nxt;
`endif

  // Zero-extend the block and put it into send order.
  always_comb begin
    w_ext        = '0;
    w_ext[W-1:0] = blk_data;
    w_load       = MSB_FIRST ? reverse_bytes(w_ext, NBYTES) : w_ext;
  end

  // Select the byte to present: data byte, or the checksum after the data.
  always_comb begin
`ifdef UART_BLOCK_CKSUM_EN
    w_cur = (r_cnt == C_CKSUM) ? r_cksum : r_shift[BYTE_W-1:0];
`else
    w_cur = r_shift[BYTE_W-1:0];
`endif
  end

  // Next-state and next-register logic for the byte sequencing FSM.
  always_comb begin
    w_state_nxt = r_state;
    w_shift_nxt = r_shift;
    w_cnt_nxt   = r_cnt;
    w_byte_nxt  = r_byte;
    w_start_nxt = r_start;
    w_busy_nxt  = r_busy;
`ifdef UART_BLOCK_CKSUM_EN
    w_cksum_nxt = r_cksum;
`endif
    case (r_state)
      S_IDLE: begin
        if (blk_valid) begin
          w_shift_nxt = w_load;
          w_cnt_nxt   = '0;
          w_busy_nxt  = 1'b1;
`ifdef UART_BLOCK_CKSUM_EN
          w_cksum_nxt = '0;
`endif
          w_state_nxt = S_SETUP;
        end
      end
      S_SETUP: begin
        // Data settles here while start is low, so the next rise is clean.
        w_byte_nxt  = w_cur;
        w_start_nxt = 1'b0;
        if (uart_tx_rdy) w_state_nxt = S_ARM;
      end
      S_ARM: begin
        w_start_nxt = 1'b1;
        w_state_nxt = S_HOLD;
      end
      S_HOLD: begin
        // Transmitter drops ready once it has latched the byte.
        if (!uart_tx_rdy) begin
          w_start_nxt = 1'b0;
          w_state_nxt = S_RELEASE;
        end
      end
      S_RELEASE: begin
        if (uart_tx_rdy) begin
`ifdef UART_BLOCK_CKSUM_EN
          if (r_cnt == C_CKSUM) begin
            w_state_nxt = S_FIN;
          end else begin
            w_cksum_nxt = r_cksum ^ r_byte;
            w_shift_nxt = {{BYTE_W{1'b0}}, r_shift[MAX_W-1:BYTE_W]};
            w_cnt_nxt   = r_cnt + C_ONE;
            w_state_nxt = S_SETUP;
          end
`else
          if (r_cnt == C_LAST) begin
            w_state_nxt = S_FIN;
          end else begin
            w_shift_nxt = {{BYTE_W{1'b0}}, r_shift[MAX_W-1:BYTE_W]};
            w_cnt_nxt   = r_cnt + C_ONE;
            w_state_nxt = S_SETUP;
          end
`endif
        end
      end
      S_FIN: begin
        w_busy_nxt  = 1'b0;
        w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // State and datapath registers; reset aborts any block in progress.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_shift <= '0;
      r_cnt   <= '0;
      r_byte  <= '0;
      r_start <= 1'b0;
      r_busy  <= 1'b0;
`ifdef UART_BLOCK_CKSUM_EN
      r_cksum <= '0;
`endif
    end else begin
      r_state <= w_state_nxt;
      r_shift <= w_shift_nxt;
      r_cnt   <= w_cnt_nxt;
      r_byte  <= w_byte_nxt;
      r_start <= w_start_nxt;
      r_busy  <= w_busy_nxt;
`ifdef UART_BLOCK_CKSUM_EN
      r_cksum <= w_cksum_nxt;
`endif
    end
  end

  assign blk_ready  = (r_state == S_IDLE);
  assign done       = (r_state == S_FIN);
  assign byte_out   = r_byte;
  assign byte_start = r_start;
  assign busy       = r_busy;

endmodule

// File: tb/tb_uart_block_sender.sv
// Directed bench for uart_block_sender: two instances (MSB-first and
// LSB-first), each driving a behavioural byte transmitter model.
module tb_uart_block_sender;
  import uart_pkg::*;

`ifdef UART_BLOCK_CKSUM_EN
  localparam int NB_SENT = 9;
`else
  localparam int NB_SENT = 8;
`endif
  localparam int TX_CYCLES = 40;  // 10 bit times at divider 4

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [63:0] r_data [2];
  logic [1:0]  r_valid = 2'b00;
  logic [1:0]  stall   = 2'b00;
  logic [1:0]  w_ready, w_start, w_busy, w_done, w_txrdy;
  logic [7:0]  w_byte [2];

  logic [1:0]  m_rdy, m_prev;
  int          m_bcnt [2] = '{default: 0};
  logic [7:0]  cap [2][256];
  int          ncap  [2] = '{default: 0};
  int          rises [2] = '{default: 0};
  int          ndone [2] = '{default: 0};

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  assign w_txrdy = m_rdy & ~stall;

  uart_block_sender #(.NBYTES(8), .MSB_FIRST(1'b1)) u_msb (
    .clk(clk), .rst(rst), .blk_data(r_data[0]), .blk_valid(r_valid[0]),
    .blk_ready(w_ready[0]), .byte_out(w_byte[0]), .byte_start(w_start[0]),
    .uart_tx_rdy(w_txrdy[0]), .busy(w_busy[0]), .done(w_done[0])
  );

  uart_block_sender #(.NBYTES(8), .MSB_FIRST(1'b0)) u_lsb (
    .clk(clk), .rst(rst), .blk_data(r_data[1]), .blk_valid(r_valid[1]),
    .blk_ready(w_ready[1]), .byte_out(w_byte[1]), .byte_start(w_start[1]),
    .uart_tx_rdy(w_txrdy[1]), .busy(w_busy[1]), .done(w_done[1])
  );

  // Transmitter model: latches byte on a start rise while ready, then busy.
  always @(posedge clk) begin
    for (int g = 0; g < 2; g++) begin
      if (w_done[g]) ndone[g] <= ndone[g] + 1;
      if (rst) begin
        m_rdy[g]  <= 1'b1;
        m_prev[g] <= 1'b0;
        m_bcnt[g] <= 0;
      end else begin
        m_prev[g] <= w_start[g];
        if (w_start[g] && !m_prev[g]) rises[g] <= rises[g] + 1;
        if (w_txrdy[g] && w_start[g] && !m_prev[g]) begin
          cap[g][ncap[g] & 255] <= w_byte[g];
          ncap[g]   <= ncap[g] + 1;
          m_rdy[g]  <= 1'b0;
          m_bcnt[g] <= TX_CYCLES;
        end else if (m_bcnt[g] > 0) begin
          m_bcnt[g] <= m_bcnt[g] - 1;
          if (m_bcnt[g] == 1) m_rdy[g] <= 1'b1;
        end
      end
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // seq lists the expected bytes in send order, first byte in [63:56].
  task automatic check_block(input int g, input int base, input logic [63:0] seq,
                             input string tag);
    logic [7:0] x;
    x = 8'h00;
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("%s_b%0d", tag, i), 64'(cap[g][(base + i) & 255]), 64'(seq[8*(7-i) +: 8]));
      x = x ^ seq[8*(7-i) +: 8];
    end
`ifdef UART_BLOCK_CKSUM_EN
    chk({tag, "_cksum"}, 64'(cap[g][(base + 8) & 255]), 64'(x));
`endif
  endtask

  task automatic send(input int g, input logic [63:0] d, input string tag);
    bit ok;
    ok = 1'b0;
    r_data[g]  = d;
    r_valid[g] = 1'b1;
    for (int t = 0; t < 200 && !ok; t++) begin
      if (w_ready[g]) ok = 1'b1;
      else @(negedge clk);
    end
    chk({tag, "_accept"}, 64'(ok), 64'd1);
    @(negedge clk);
    r_valid[g] = 1'b0;
  endtask

  task automatic wait_done(input int g, input string tag);
    bit ok;
    ok = 1'b0;
    for (int t = 0; t < 3000 && !ok; t++) begin
      @(negedge clk);
      if (w_done[g]) ok = 1'b1;
    end
    chk({tag, "_done"}, 64'(ok), 64'd1);
    @(negedge clk);
    chk({tag, "_busy_low"}, 64'(w_busy[g]), 64'd0);
    chk({tag, "_ready_back"}, 64'(w_ready[g]), 64'd1);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int  base, base_r, base_d, snap_c, snap_r, snap_d;
    int  cnt, t, acc, dn, acc_t2, done_t1;
    bit  ok, any_start, all_setup, prev_s, pend_b, pend_clr;

    r_data[0] = '0;
    r_data[1] = '0;

    // Reset values
    repeat (3) @(negedge clk);
    chk("rst_ready", 64'(w_ready[0]), 64'd1);
    chk("rst_byte", 64'(w_byte[0]), 64'd0);
    chk("rst_start", 64'(w_start[0]), 64'd0);
    chk("rst_busy", 64'(w_busy[0]), 64'd0);
    chk("rst_done", 64'(w_done[0]), 64'd0);
    rst = 1'b0;
    @(negedge clk);

    // Basic MSB-first order
    base = ncap[0]; base_r = rises[0]; base_d = ndone[0];
    send(0, 64'h0123456789ABCDEF, "msb");
    wait_done(0, "msb");
    chk("msb_count", 64'(ncap[0] - base), 64'(NB_SENT));
    chk("msb_rises", 64'(rises[0] - base_r), 64'(NB_SENT));
    chk("msb_ndone", 64'(ndone[0] - base_d), 64'd1);
    check_block(0, base, 64'h0123456789ABCDEF, "msb");

    // LSB-first order on the second instance
    base = ncap[1];
    send(1, 64'h0123456789ABCDEF, "lsb");
    wait_done(1, "lsb");
    chk("lsb_count", 64'(ncap[1] - base), 64'(NB_SENT));
    check_block(1, base, 64'hEFCDAB8967452301, "lsb");

    // Stalled transmitter at accept
    base = ncap[0];
    stall[0] = 1'b1;
    send(0, 64'hDEADBEEFCAFEF00D, "stall");
    any_start = 1'b0; all_setup = 1'b1;
    repeat (20) begin
      @(negedge clk);
      any_start = any_start | w_start[0];
      all_setup = all_setup & (u_msb.r_state == S_SETUP);
    end
    chk("stall_no_start", 64'(any_start), 64'd0);
    chk("stall_in_setup", 64'(all_setup), 64'd1);
    stall[0] = 1'b0;
    cnt = 0; ok = 1'b0;
    for (int k = 0; k < 20 && !ok; k++) begin
      @(negedge clk);
      cnt++;
      if (w_start[0]) ok = 1'b1;
    end
    chk("stall_rise_latency", 64'(cnt), 64'd2);
    wait_done(0, "stall");
    check_block(0, base, 64'hDEADBEEFCAFEF00D, "stall");

    // Back-to-back blocks with valid held high
    base = ncap[0]; base_r = rises[0];
    r_data[0] = 64'hFFFF0000AAAA5555;
    r_valid[0] = 1'b1;
    acc = 0; dn = 0; acc_t2 = -1; done_t1 = -100; pend_b = 1'b0; pend_clr = 1'b0;
    t = 0;
    while (t < 6000 && dn < 2) begin
      if (pend_b) begin r_data[0] = 64'h0000000000000001; pend_b = 1'b0; end
      if (pend_clr) begin r_valid[0] = 1'b0; pend_clr = 1'b0; end
      if (w_ready[0] && r_valid[0]) begin
        acc++;
        if (acc == 1) pend_b = 1'b1;
        else begin acc_t2 = t; pend_clr = 1'b1; end
      end
      if (w_done[0]) begin
        dn++;
        if (dn == 1) done_t1 = t;
      end
      @(negedge clk);
      t++;
    end
    if (pend_clr) r_valid[0] = 1'b0;
    chk("b2b_two_done", 64'(dn), 64'd2);
    chk("b2b_accepts", 64'(acc), 64'd2);
    chk("b2b_gap", 64'(acc_t2 - done_t1), 64'd1);
    @(negedge clk);
    chk("b2b_count", 64'(ncap[0] - base), 64'(2 * NB_SENT));
    chk("b2b_rises", 64'(rises[0] - base_r), 64'(2 * NB_SENT));
    check_block(0, base, 64'hFFFF0000AAAA5555, "b2b_a");
    check_block(0, base + NB_SENT, 64'h0000000000000001, "b2b_b");

    // Reset in the middle of a block
    send(0, 64'hA1A2A3A4A5A6A7A8, "abort");
    cnt = 0; ok = 1'b0; prev_s = w_start[0];
    for (int k = 0; k < 2000 && !ok; k++) begin
      @(negedge clk);
      if (w_start[0] && !prev_s) cnt++;
      prev_s = w_start[0];
      if (cnt == 3) ok = 1'b1;
    end
    chk("abort_third_rise", 64'(ok), 64'd1);
    rst = 1'b1;
    @(negedge clk);
    chk("abort_start", 64'(w_start[0]), 64'd0);
    chk("abort_busy", 64'(w_busy[0]), 64'd0);
    chk("abort_ready", 64'(w_ready[0]), 64'd1);
    rst = 1'b0;
    snap_c = ncap[0]; snap_r = rises[0]; snap_d = ndone[0];
    repeat (100) @(negedge clk);
    chk("abort_no_resend", 64'(ncap[0] - snap_c), 64'd0);
    chk("abort_no_rise", 64'(rises[0] - snap_r), 64'd0);
    chk("abort_no_done", 64'(ndone[0] - snap_d), 64'd0);
    base = ncap[0];
    send(0, 64'h8877665544332211, "after");
    wait_done(0, "after");
    chk("after_count", 64'(ncap[0] - base), 64'(NB_SENT));
    check_block(0, base, 64'h8877665544332211, "after");

`ifdef UART_BLOCK_CKSUM_EN
    // Checksum byte values
    base = ncap[0];
    send(0, 64'h0102040810204080, "ck1");
    wait_done(0, "ck1");
    chk("ck1_count", 64'(ncap[0] - base), 64'd9);
    chk("ck1_last", 64'(cap[0][(base + 8) & 255]), 64'hFF);
    base = ncap[0];
    send(0, 64'h0101010101010101, "ck2");
    wait_done(0, "ck2");
    chk("ck2_count", 64'(ncap[0] - base), 64'd9);
    chk("ck2_last", 64'(cap[0][(base + 8) & 255]), 64'h00);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
